// File: rtl/register_serializer.sv
// Parallel-to-serial converter: captures one word from a register output and
// shifts it out one bit per accepted handshake, then pulses done.
module register_serializer #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             out_ready,
    output logic             last,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, nstate;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             cnt_last;
    logic             cur_bit;

    assign cnt_last = (cnt == CW'(WIDTH - 1));
    assign cur_bit  = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (valid) nstate = SHIFT;
            SHIFT:   if (out_ready && cnt_last) nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Outputs decode registered state only, so reset clears them without a clock.
    always_comb begin
        ready      = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        last       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:  ready = 1'b1;
            SHIFT: begin
                sout_valid = 1'b1;
                sout       = cur_bit;
                last       = cnt_last;
            end
            DONE:  done = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Counter wraps to 0 on the final bit so it never exceeds WIDTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (state == IDLE && valid) begin
            sreg <= data;
            cnt  <= '0;
        end else if (state == SHIFT && out_ready) begin
            if (MSB_FIRST) sreg <= {sreg[WIDTH-2:0], 1'b0};
            else           sreg <= {1'b0, sreg[WIDTH-1:1]};
            cnt <= cnt_last ? '0 : cnt + CW'(1);
        end
    end
endmodule
